// File: rtl/trace_reader.sv
// trace_reader: readback engine that issues in-order sample reads, decodes run-length intervals into timestamps and streams them out.
// Ports: clk/reset (synchronous, active-high); start, abort, begin_num, end_num: run control;
//        busy, done: status; rd_req, rd_req_ready, rd_num: read request channel;
//        rd_rsp_valid, rd_rsp_data: in-order returned packets {interval, data};
//        out_valid, out_ready, out_data, out_time, out_last: decoded sample stream.
module trace_reader #(
    parameter int          SAMPLE_WIDTH        = 16,
    parameter int          SAMPLE_PACKET_WIDTH = 32,
    parameter logic [31:0] MAX_SAMPLE_NUMBER   = 32'h01FF_FFFF,
    parameter int          MAX_OUTSTANDING     = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [31:0]                    begin_num,
    input  logic [31:0]                    end_num,
    output logic                           busy,
    output logic                           done,
    output logic                           rd_req,
    input  logic                           rd_req_ready,
    output logic [31:0]                    rd_num,
    input  logic                           rd_rsp_valid,
    input  logic [SAMPLE_PACKET_WIDTH-1:0] rd_rsp_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SAMPLE_WIDTH-1:0]        out_data,
    output logic [31:0]                    out_time,
    output logic                           out_last
);
    localparam int IW = SAMPLE_PACKET_WIDTH - SAMPLE_WIDTH;
    localparam int AW = $clog2(MAX_OUTSTANDING);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;

    state_t                         state_q, state_d;
    logic [31:0]                    next_num_q, next_num_d, rem_req_q, rem_req_d, rem_out_q, rem_out_d;
    logic [31:0]                    out_time_q, out_time_d, total;
    logic                           first_q, first_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [SAMPLE_WIDTH-1:0]        out_data_q, out_data_d;
    logic [CW-1:0]                  outst_q, outst_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_count;
    logic [SAMPLE_PACKET_WIDTH-1:0] fifo_q [MAX_OUTSTANDING];
    logic [SAMPLE_PACKET_WIDTH-1:0] head;
    logic [IW-1:0]                  interval;
    logic                           active, kill, req_acc, rsp_ok, push, pop, out_acc;

    assign active     = state_q == READ || state_q == DRAIN;
    assign kill       = active && abort;
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    // Ring distance: a wrapped capture spans the tail up to MAX plus the head from 0.
    assign total      = end_num >= begin_num ? end_num - begin_num + 32'd1
                                             : MAX_SAMPLE_NUMBER - begin_num + end_num + 32'd2;
    assign req_acc    = rd_req && rd_req_ready;
    assign rsp_ok     = rd_rsp_valid && outst_q != '0;
    // Responses still in flight after an abort only return their credit.
    assign push       = rsp_ok && active && !abort;
    assign out_acc    = out_valid && out_ready;
    assign pop        = active && !abort && fifo_count != '0 && (!out_valid_q || out_ready);
    assign head       = fifo_q[rd_ptr_q[AW-1:0]];
    assign interval   = head[SAMPLE_PACKET_WIDTH-1:SAMPLE_WIDTH];

    always_ff @(posedge clk) begin
        state_q <= reset ? IDLE : state_d;
    end

    always_comb begin
        state_d = state_q == IDLE  ? (start ? READ : IDLE)
                : state_q == FLUSH ? (outst_q == '0 ? IDLE : FLUSH)
                : abort            ? FLUSH
                : state_q == READ  ? (req_acc && rem_req_q == 32'd1 ? DRAIN : READ)
                :                    (out_acc && rem_out_q == 32'd1 ? IDLE : DRAIN);
    end

    // Credits cover both unanswered requests and queued packets, so the FIFO cannot overflow.
    always_comb begin
        busy      = state_q != IDLE;
        rd_req    = state_q == READ && !abort && rem_req_q != '0
                    && 32'(outst_q) + 32'(fifo_count) < 32'(MAX_OUTSTANDING);
        out_valid = out_valid_q && !kill;
        done      = active && out_acc && rem_out_q == 32'd1;
    end

    always_comb begin
        next_num_d = next_num_q;
        rem_req_d  = rem_req_q;
        rem_out_d  = out_acc ? rem_out_q - 32'd1 : rem_out_q;
        first_d    = first_q && !pop;
        if (state_q == IDLE && start) begin
            next_num_d = begin_num;
            rem_req_d  = total;
            rem_out_d  = total;
            first_d    = 1'b1;
        end
        if (req_acc) begin
            next_num_d = next_num_q == MAX_SAMPLE_NUMBER ? 32'd0 : next_num_q + 32'd1;
            rem_req_d  = rem_req_q - 32'd1;
        end
        outst_d     = outst_q + CW'(req_acc) - CW'(rsp_ok);
        wr_ptr_d    = kill ? '0 : wr_ptr_q + CW'(push);
        rd_ptr_d    = kill ? '0 : rd_ptr_q + CW'(pop);
        out_valid_d = !kill && (pop || (out_valid_q && !out_acc));
        out_data_d  = pop ? head[SAMPLE_WIDTH-1:0] : out_data_q;
        out_time_d  = pop ? (first_q ? 32'd0 : out_time_q + 32'(interval) + 32'd1) : out_time_q;
        // Samples not yet accepted, excluding the one leaving the register this cycle.
        out_last_d  = pop ? rem_out_q - 32'(out_acc) == 32'd1 : out_last_q;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[AW-1:0]] <= rd_rsp_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_num_q  <= '0;
            rem_req_q   <= '0;
            rem_out_q   <= '0;
            first_q     <= 1'b0;
            outst_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_time_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            next_num_q  <= next_num_d;
            rem_req_q   <= rem_req_d;
            rem_out_q   <= rem_out_d;
            first_q     <= first_d;
            outst_q     <= outst_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_time_q  <= out_time_d;
            out_last_q  <= out_last_d;
        end
    end

    assign rd_num   = next_num_q;
    assign out_data = out_data_q;
    assign out_time = out_time_q;
    assign out_last = out_last_q;
endmodule

// File: tb/tb_trace_reader.sv
// tb_trace_reader: directed checks of trace_reader against a delayed in-order memory model.
module tb_trace_reader;
    localparam logic [31:0] MAX = 32'h01FF_FFFF;

    logic        clk = 1'b0;
    logic        reset, start, abort, rd_req_ready, out_ready;
    logic        rd_rsp_valid = 1'b0;
    logic [31:0] rd_rsp_data = '0;
    logic [31:0] begin_num, end_num, rd_num, out_time;
    logic [15:0] out_data;
    logic        busy, done, rd_req, out_valid, out_last;

    int n_assert = 0, n_fail = 0;
    int cyc = 0, mem_delay = 1;
    int n_req = 0, n_rsp = 0, n_out = 0, done_cnt = 0, done_at = -1, max_unans = 0, stall_viol = 0;
    int b_out, b_req, b_done, rsp_at_idle;
    logic        busy_after_done = 1'b1, done_prev = 1'b0, stall_prev = 1'b0;
    logic [15:0] stall_d;
    logic [31:0] stall_t, r_begin;
    logic [31:0] req_log [512];
    int          rsp_due [512];
    logic [31:0] pkt_tbl [512];
    logic [15:0] log_data [512];
    logic [31:0] log_time [512];
    logic        log_last [512];
    logic [15:0] iv1 [8];
    logic [31:0] exp1 [8];

    trace_reader #(
        .SAMPLE_WIDTH(16), .SAMPLE_PACKET_WIDTH(32), .MAX_SAMPLE_NUMBER(MAX), .MAX_OUTSTANDING(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .begin_num(begin_num), .end_num(end_num), .busy(busy), .done(done),
        .rd_req(rd_req), .rd_req_ready(rd_req_ready), .rd_num(rd_num),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_time(out_time), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Memory: returns the packet for each accepted request mem_delay cycles later, in order.
    always @(posedge clk) begin
        cyc++;
        #1;
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        if (n_rsp < n_req && rsp_due[n_rsp] <= cyc) begin
            rd_rsp_valid = 1'b1;
            rd_rsp_data  = pkt_tbl[n_rsp];
            n_rsp++;
        end
    end

    always @(negedge clk) begin
        if (n_req - n_rsp > max_unans) max_unans = n_req - n_rsp;
        if (rd_req === 1'b1 && rd_req_ready) begin
            req_log[n_req] = rd_num;
            rsp_due[n_req] = cyc + mem_delay;
            n_req++;
        end
        if (out_valid === 1'b1 && out_ready) begin
            log_data[n_out] = out_data;
            log_time[n_out] = out_time;
            log_last[n_out] = out_last;
            n_out++;
        end
        if (done_prev) busy_after_done = busy;
        done_prev = done === 1'b1;
        if (done === 1'b1) begin
            done_cnt++;
            done_at = (out_valid === 1'b1 && out_ready) ? n_out - 1 : -1;
        end
        if (stall_prev && !(out_valid === 1'b1 && out_data === stall_d && out_time === stall_t)) stall_viol++;
        stall_prev = out_valid === 1'b1 && !out_ready;
        stall_d    = out_data;
        stall_t    = out_time;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic begin_run(input logic [31:0] b, input logic [31:0] e);
        b_out     = n_out;
        b_req     = n_req;
        b_done    = done_cnt;
        r_begin   = b;
        begin_num = b;
        end_num   = e;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        rsp_at_idle = n_rsp;
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (2) tick();
    endtask

    task automatic finish_run(input string tag, input int n);
        logic [31:0] num, t;
        wait_idle(tag, 3000);
        chk({tag, "_n_out"}, 32'(n_out - b_out), 32'(n));
        chk({tag, "_n_req"}, 32'(n_req - b_req), 32'(n));
        num = r_begin;
        t   = '0;
        for (int k = 0; k < n; k++) begin
            t = (k == 0) ? 32'd0 : t + 32'(pkt_tbl[b_req + k][31:16]) + 32'd1;
            chk({tag, "_rd_num"}, req_log[b_req + k], num);
            chk({tag, "_data"}, 32'(log_data[b_out + k]), 32'(pkt_tbl[b_req + k][15:0]));
            chk({tag, "_time"}, log_time[b_out + k], t);
            chk({tag, "_last"}, 32'(log_last[b_out + k]), 32'(k == n - 1));
            num = (num == MAX) ? 32'd0 : num + 32'd1;
        end
        chk({tag, "_done_cnt"}, 32'(done_cnt - b_done), 32'd1);
        chk({tag, "_done_at"}, 32'(done_at), 32'(b_out + n - 1));
        chk({tag, "_busy_after_done"}, 32'(busy_after_done), 32'd0);
    endtask

    initial begin
        iv1  = '{16'h1234, 16'd0, 16'd0, 16'd3, 16'd0, 16'd9, 16'd0, 16'd0};
        exp1 = '{32'd0, 32'd1, 32'd2, 32'd6, 32'd7, 32'd17, 32'd18, 32'd19};
        reset = 1'b1; start = 1'b0; abort = 1'b0; begin_num = '0; end_num = '0;
        rd_req_ready = 1'b1; out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_rd_num", rd_num, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_time", out_time, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);

        for (int k = 0; k < 8; k++) pkt_tbl[n_req + k] = {iv1[k], 16'(k)};
        begin_run(32'd0, 32'd7);
        finish_run("basic", 8);
        for (int k = 0; k < 8; k++) chk("basic_time_hand", log_time[b_out + k], exp1[k]);

        for (int k = 0; k < 8; k++) pkt_tbl[n_req + k] = {16'(k), 16'hA000 + 16'(k)};
        begin_run(MAX - 32'd3, 32'd3);
        finish_run("wrap", 8);
        chk("wrap_top", req_log[b_req + 3], MAX);
        chk("wrap_zero", req_log[b_req + 4], 32'd0);

        mem_delay = 20;
        for (int k = 0; k < 32; k++) pkt_tbl[n_req + k] = {16'(k % 3), 16'(k * 7)};
        begin_run(32'd100, 32'd131);
        repeat (3) tick();
        begin_num = 32'd999; end_num = 32'd999; start = 1'b1;
        tick();
        start = 1'b0;
        finish_run("credit", 32);
        chk("credit_max_unanswered", 32'(max_unans), 32'd8);

        mem_delay = 1;
        for (int k = 0; k < 24; k++) pkt_tbl[n_req + k] = {16'(k), 16'hB000 + 16'(k)};
        begin_run(32'd0, 32'd23);
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 2) == 1;
            tick();
        end
        out_ready = 1'b0;
        repeat (50) tick();
        chk("bp_rd_req_off", 32'(rd_req), 32'd0);
        chk("bp_valid_held", 32'(out_valid), 32'd1);
        chk("bp_fill", 32'(n_req - b_req), 32'(n_out - b_out + 9));
        out_ready = 1'b1;
        finish_run("bp", 24);
        chk("bp_stall_stable", 32'(stall_viol), 32'd0);

        mem_delay = 30;
        for (int k = 0; k < 16; k++) pkt_tbl[n_req + k] = {16'd5, 16'hD000 + 16'(k)};
        begin_run(32'd0, 32'd15);
        for (int i = 0; i < 100 && (n_req - b_req) < 5; i++) tick();
        abort = 1'b1;
        @(negedge clk);
        chk("abort_rd_req", 32'(rd_req), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        tick();
        abort = 1'b0;
        wait_idle("abort", 200);
        chk("abort_req_cnt", 32'(n_req - b_req), 32'd5);
        chk("abort_wait_rsp", 32'(rsp_at_idle), 32'(n_req));
        chk("abort_no_out", 32'(n_out - b_out), 32'd0);
        chk("abort_no_done", 32'(done_cnt - b_done), 32'd0);

        mem_delay = 1;
        pkt_tbl[n_req]     = {16'h00FF, 16'hC000};
        pkt_tbl[n_req + 1] = {16'd2, 16'hC001};
        pkt_tbl[n_req + 2] = {16'd0, 16'hC002};
        pkt_tbl[n_req + 3] = {16'd1, 16'hC003};
        begin_run(32'd40, 32'd43);
        finish_run("restart", 4);
        chk("restart_t0", log_time[b_out], 32'd0);
        chk("restart_t1", log_time[b_out + 1], 32'd3);
        chk("restart_t3", log_time[b_out + 3], 32'd6);

        for (int k = 0; k < 3; k++) pkt_tbl[n_req + k] = {16'hFFFF, 16'(k)};
        begin_run(32'd200, 32'd202);
        finish_run("ones", 3);
        chk("ones_t1", log_time[b_out + 1], 32'd65536);
        chk("ones_t2", log_time[b_out + 2], 32'd131072);

        pkt_tbl[n_req] = {16'h0042, 16'h5A5A};
        begin_run(32'd500, 32'd500);
        finish_run("single", 1);
        chk("max_unanswered_final", 32'(max_unans), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
